trigger_capture: RTL and testbench
==================================

TRIGGER_CAPTURE -- requirements
Module: trigger_capture

Interface
REQ-001 Parameter: N_MEAS, 1024, samples per measurement window used to compute the trigger level.
REQ-002 Parameter: POST_SAMPLES, 5120, samples written after the trigger sample (8 x 640, the largest display span).
REQ-003 Parameter: ARM_TIMEOUT, 65535, accepted samples in ARM before auto-trigger.
REQ-004 Port: CLOCK_50  in  1  system clock, 50 MHz; sole clock; all logic on rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: adc_valid  in  1  one-cycle strobe; adc_data is valid this cycle.
REQ-007 Port: adc_data  in  12  unsigned ADC sample.
REQ-008 Port: frame_done  in  1  one-cycle pulse from the display side; the captured buffer has been shown and may be overwritten.
REQ-009 Port: wr_en  out  1  sample RAM write enable.
REQ-010 Port: wr_addr  out  16  sample RAM write address.
REQ-011 Port: wr_data  out  12  sample RAM write data.
REQ-012 Port: mean_addr  out  16  RAM address of the trigger sample; the display reads from here upward.
REQ-013 Port: mean_addr_found  out  1  high while a complete capture is held and mean_addr is valid.
REQ-014 Port: level  out  12  current trigger level.

Function
REQ-015 FSM states: IDLE, MEASURE, ARM, POST, HOLD.
REQ-016 IDLE shall go to MEASURE on the next cycle with no other action.
REQ-017 Sample acceptance shall work as follows in MEASURE, ARM and POST.
- An adc_valid cycle drives wr_en=1, wr_data=adc_data and wr_addr=ptr on the next cycle.
- ptr then increments by 1 and wraps from 0xFFFF to 0x0000.
- wr_en shall be 0 in every other cycle.
REQ-018 MEASURE shall do the following:
- Track the running min and max of the accepted samples, initialised to 0xFFF and 0x000 on entry.
- After N_MEAS samples, set level = (min+max)>>1, computed with a 13-bit sum and truncated to 12 bits.
- Go to ARM.
REQ-019 ARM trigger condition: an accepted sample with prev < level and adc_data >= level, where prev is the previously accepted sample.
- The first sample accepted in ARM shall never trigger.
REQ-020 On trigger, mean_addr shall take the address that sample is written to, and the FSM shall go to POST.
REQ-021 If ARM_TIMEOUT samples are accepted in ARM without a trigger, the block shall auto-trigger on the next accepted sample.
- mean_addr shall be that sample's address.
- The FSM shall go to POST.
REQ-022 POST shall accept exactly POST_SAMPLES samples after the trigger sample, then go to HOLD.
REQ-023 HOLD shall work as follows:
- mean_addr_found=1.
- wr_en=0, and adc_valid is ignored, so RAM contents are frozen.
- On frame_done, the next cycle has mean_addr_found=0 and the FSM in MEASURE.
REQ-024 mean_addr_found shall be 0 in every state except HOLD.
- mean_addr shall change only on a trigger.
REQ-025 frame_done outside HOLD shall be ignored.
REQ-026 frame_done and adc_valid asserted together in HOLD shall cause no write.
REQ-027 ptr is not reset between captures; a new capture continues from the current ptr with wrap-around.
REQ-028 level shall hold its last computed value until the next MEASURE completes.

Reset
REQ-029 Reset, sampled on a rising edge, shall produce the following values on the next cycle:
- state=IDLE, ptr=0, prev=0, counters=0.
- wr_en=0, wr_addr=0, wr_data=0.
- mean_addr=0, mean_addr_found=0.
- level=0x800.
REQ-030 Reset shall take priority over all other inputs.
REQ-031 Reset asserted mid-capture, including in POST or HOLD, shall abort the capture with no further write.

Verification
REQ-032 Ramp trigger (N_MEAS=4): samples 0x100, 0xF00, 0x100, 0xF00 set level=0x800. Then 0x700, 0x900 give a trigger on 0x900 at address 5, so mean_addr=5. After POST_SAMPLES more samples, mean_addr_found=1.
REQ-033 Flat input: constant 0x400 gives level=0x400 and no crossing. After ARM_TIMEOUT+1 samples in ARM, auto-trigger; mean_addr equals that sample's address.
REQ-034 Wrap: ptr preset near 0xFFFE by feeding samples, with the trigger at 0xFFFE. Then mean_addr=0xFFFE and POST writes continue at 0xFFFF, 0x0000, 0x0001.
REQ-035 HOLD freeze: adc_valid pulsed 100 times in HOLD gives wr_en=0 throughout. A frame_done pulse then gives mean_addr_found=0 on the next cycle, and MEASURE writes resume at the unchanged ptr.
REQ-036 Reset mid-POST: reset asserted after 10 POST samples gives wr_en=0, mean_addr=0, mean_addr_found=0 and level=0x800 on the next cycle.
REQ-037 Falling edge only: 0x900 then 0x700 with level=0x800 gives no trigger.

Source files
------------

// File: rtl/trigger_capture.sv
// ----------------------------------------------------------------------------
// trigger_capture
//
// Oscilloscope-style trigger and capture controller. Incoming ADC samples are
// written into a 64K-entry sample RAM through a free-running, wrapping write
// pointer.
//
// Each capture runs through these phases:
//   MEASURE : the min/max of a window of samples sets the trigger level
//             (midpoint).
//   ARM     : waits for a rising crossing of that level, or auto-triggers
//             after a quiet period.
//   POST    : writes a fixed number of samples after the trigger sample.
//   HOLD    : freezes the RAM and publishes the trigger address until the
//             display reports that it has shown the frame.
//
// Parameters
//   N_MEAS        samples per measurement window
//   POST_SAMPLES  samples written after the trigger sample
//   ARM_TIMEOUT   samples accepted in ARM before an automatic trigger
//
// Ports
//   CLOCK_50         in   system clock; all logic uses its rising edge
//   reset            in   synchronous, active-high reset
//   adc_valid        in   one-cycle strobe qualifying adc_data
//   adc_data[11:0]   in   unsigned ADC sample
//   frame_done       in   display has shown the held buffer
//   wr_en            out  sample RAM write enable
//   wr_addr[15:0]    out  sample RAM write address
//   wr_data[11:0]    out  sample RAM write data
//   mean_addr[15:0]  out  RAM address of the trigger sample
//   mean_addr_found  out  high while a complete capture is held
//   level[11:0]      out  current trigger level
// ----------------------------------------------------------------------------
module trigger_capture #(
  parameter int N_MEAS       = 1024,
  parameter int POST_SAMPLES = 5120,
  parameter int ARM_TIMEOUT  = 65535
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        adc_valid,
  input  logic [11:0] adc_data,
  input  logic        frame_done,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [11:0] wr_data,
  output logic [15:0] mean_addr,
  output logic        mean_addr_found,
  output logic [11:0] level
);

  localparam int DATA_W = 12;
  localparam int ADDR_W = 16;

  // One shared sample counter serves all three sample-consuming phases, so it
  // is sized for the largest limit. The extra bit keeps cnt_q + 1 from
  // wrapping at the top of the range.
  localparam int MAX_A   = (N_MEAS > POST_SAMPLES) ? N_MEAS : POST_SAMPLES;
  localparam int MAX_CNT = (MAX_A > ARM_TIMEOUT) ? MAX_A : ARM_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_CNT + 1) + 1;

  localparam logic [CNT_W-1:0] MEAS_LAST = CNT_W'(N_MEAS - 1);
  localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_SAMPLES - 1);
  localparam logic [CNT_W-1:0] ARM_LIMIT = CNT_W'(ARM_TIMEOUT);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_MEASURE = 3'd1;
  localparam logic [2:0] ST_ARM     = 3'd2;
  localparam logic [2:0] ST_POST    = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;

  localparam logic [DATA_W-1:0] LEVEL_RESET = 12'h800;
  localparam logic [DATA_W-1:0] MIN_INIT    = 12'hFFF;
  localparam logic [DATA_W-1:0] MAX_INIT    = 12'h000;

  // Midpoint of the measured range. The sum is taken over 13 bits so that it
  // cannot overflow, and the result is truncated.
  function automatic logic [DATA_W-1:0] mid_level(input logic [DATA_W-1:0] lo,
                                                  input logic [DATA_W-1:0] hi);
    logic [DATA_W:0] sum;
    sum = {1'b0, lo} + {1'b0, hi};
    return sum[DATA_W:1];
  endfunction

  function automatic logic [DATA_W-1:0] min12(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DATA_W-1:0] max12(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [2:0]        state_q,     state_d;
  logic [ADDR_W-1:0] ptr_q,       ptr_d;
  logic [DATA_W-1:0] prev_q,      prev_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [DATA_W-1:0] min_q,       min_d;
  logic [DATA_W-1:0] max_q,       max_d;
  logic [DATA_W-1:0] level_q,     level_d;
  logic [ADDR_W-1:0] mean_addr_q, mean_addr_d;
  logic              wr_en_q,     wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
  logic [DATA_W-1:0] wr_data_q,   wr_data_d;

  logic              accept;
  logic              crossing;
  logic [DATA_W-1:0] new_min;
  logic [DATA_W-1:0] new_max;

  // Samples are taken only in the three capture phases; HOLD and IDLE ignore
  // adc_valid entirely, which is what freezes the RAM while it is displayed.
  assign accept = adc_valid &&
                  ((state_q == ST_MEASURE) || (state_q == ST_ARM) || (state_q == ST_POST));

  // A rising crossing needs a previous ARM sample. cnt_q counts the ARM
  // samples seen so far, so the first sample in ARM can never trigger, even
  // though prev_q still holds the last MEASURE sample.
  assign crossing = (cnt_q != '0) && (prev_q < level_q) && (adc_data >= level_q);

  assign new_min = min12(min_q, adc_data);
  assign new_max = max12(max_q, adc_data);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    prev_d      = prev_q;
    cnt_d       = cnt_q;
    min_d       = min_q;
    max_d       = max_q;
    level_d     = level_q;
    mean_addr_d = mean_addr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    if (accept) begin
      wr_en_d   = 1'b1;
      wr_addr_d = ptr_q;
      wr_data_d = adc_data;
      ptr_d     = ptr_q + 16'd1;
      prev_d    = adc_data;
    end

    case (state_q)
      ST_IDLE: begin
        state_d = ST_MEASURE;
        cnt_d   = '0;
        min_d   = MIN_INIT;
        max_d   = MAX_INIT;
      end

      ST_MEASURE: begin
        if (adc_valid) begin
          min_d = new_min;
          max_d = new_max;
          if (cnt_q == MEAS_LAST) begin
            level_d = mid_level(new_min, new_max);
            state_d = ST_ARM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_ARM: begin
        if (adc_valid) begin
          if (crossing || (cnt_q == ARM_LIMIT)) begin
            mean_addr_d = ptr_q;
            state_d     = ST_POST;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_POST: begin
        if (adc_valid) begin
          if (cnt_q == POST_LAST) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (frame_done) begin
          state_d = ST_MEASURE;
          cnt_d   = '0;
          min_d   = MIN_INIT;
          max_d   = MAX_INIT;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---- register stage: state, pointer and registered RAM write port ----
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      prev_q      <= '0;
      cnt_q       <= '0;
      min_q       <= MIN_INIT;
      max_q       <= MAX_INIT;
      level_q     <= LEVEL_RESET;
      mean_addr_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      min_q       <= min_d;
      max_q       <= max_d;
      level_q     <= level_d;
      mean_addr_q <= mean_addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign wr_en           = wr_en_q;
  assign wr_addr         = wr_addr_q;
  assign wr_data         = wr_data_q;
  assign mean_addr       = mean_addr_q;
  assign mean_addr_found = (state_q == ST_HOLD);
  assign level           = level_q;

endmodule

// File: tb/tb_trigger_capture.sv
`timescale 1ns/1ps
module tb_trigger_capture;

  localparam int N_MEAS       = 4;
  localparam int POST_SAMPLES = 30;
  localparam int ARM_TIMEOUT  = 40;

  localparam int PH_IDLE    = 0;
  localparam int PH_MEASURE = 1;
  localparam int PH_ARM     = 2;
  localparam int PH_POST    = 3;
  localparam int PH_HOLD    = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        adc_valid = 1'b0;
  logic [11:0] adc_data = '0;
  logic        frame_done = 1'b0;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [11:0] wr_data;
  logic [15:0] mean_addr;
  logic        mean_addr_found;
  logic [11:0] level;

  trigger_capture #(
    .N_MEAS      (N_MEAS),
    .POST_SAMPLES(POST_SAMPLES),
    .ARM_TIMEOUT (ARM_TIMEOUT)
  ) dut (
    .CLOCK_50       (clk),
    .reset          (reset),
    .adc_valid      (adc_valid),
    .adc_data       (adc_data),
    .frame_done     (frame_done),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .mean_addr      (mean_addr),
    .mean_addr_found(mean_addr_found),
    .level          (level)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: capture phase, sample lists and counts kept as plain
  // integers and a queue, advanced once per clock from the applied inputs.
  int m_phase = PH_IDLE;
  int m_ptr = 0, m_prev = 0, m_level = 12'h800, m_mean = 0;
  int m_arm_n = 0, m_post_n = 0;
  int m_meas[$];
  bit m_wr_en = 0;
  int m_wr_addr = 0, m_wr_data = 0;

  task automatic model_step(input bit r, input bit v, input int d, input bit fd);
    m_wr_en = 0;
    if (r) begin
      m_phase = PH_IDLE; m_ptr = 0; m_prev = 0; m_level = 12'h800; m_mean = 0;
      m_arm_n = 0; m_post_n = 0; m_meas.delete();
      return;
    end
    case (m_phase)
      PH_IDLE: begin
        m_phase = PH_MEASURE;
        m_meas.delete();
      end
      PH_HOLD: begin
        if (fd) begin
          m_phase = PH_MEASURE;
          m_meas.delete();
        end
      end
      default: begin
        if (v) begin
          m_wr_en = 1; m_wr_addr = m_ptr; m_wr_data = d;
          if (m_phase == PH_MEASURE) begin
            m_meas.push_back(d);
            if (m_meas.size() == N_MEAS) begin
              int mn, mx;
              mn = 4095; mx = 0;
              foreach (m_meas[i]) begin
                if (m_meas[i] < mn) mn = m_meas[i];
                if (m_meas[i] > mx) mx = m_meas[i];
              end
              m_level = (mn + mx) / 2;
              m_phase = PH_ARM;
              m_arm_n = 0;
            end
          end else if (m_phase == PH_ARM) begin
            if ((m_arm_n > 0 && m_prev < m_level && d >= m_level) || m_arm_n == ARM_TIMEOUT) begin
              m_mean = m_ptr;
              m_phase = PH_POST;
              m_post_n = 0;
            end else begin
              m_arm_n++;
            end
          end else begin
            m_post_n++;
            if (m_post_n == POST_SAMPLES) m_phase = PH_HOLD;
          end
          m_prev = d;
          m_ptr = (m_ptr + 1) % 65536;
        end
      end
    endcase
  endtask

  task automatic step(input bit r, input bit v, input int d, input bit fd);
    reset = r; adc_valid = v; adc_data = d[11:0]; frame_done = fd;
    @(posedge clk);
    #1;
    model_step(r, v, d & 12'hFFF, fd);
    check_val("wr_en", wr_en, m_wr_en);
    if (m_wr_en) begin
      check_val("wr_addr", wr_addr, m_wr_addr);
      check_val("wr_data", wr_data, m_wr_data);
    end
    check_val("mean_addr", mean_addr, m_mean);
    check_val("mean_addr_found", mean_addr_found, m_phase == PH_HOLD);
    check_val("level", level, m_level);
  endtask

  task automatic sample(input int d);
    step(0, 1, d, 0);
  endtask

  task automatic measure4(input int a, input int b, input int c, input int e);
    sample(a); sample(b); sample(c); sample(e);
  endtask

  task automatic finish_post_random();
    int guard;
    guard = 0;
    while (m_phase == PH_POST && guard < 2000) begin
      step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 4095), 0);
      guard++;
    end
    check_val("post_done", mean_addr_found, 1);
  endtask

  task automatic release_hold();
    step(0, 1, $urandom_range(0, 4095), 1);
    check_val("release_found", mean_addr_found, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r_dist, a_len, guard, base;

    // Reset, including reset winning over valid and frame_done.
    step(1, 0, 0, 0);
    step(1, 1, 12'h123, 1);
    check_val("rst_wr_en", wr_en, 0);
    check_val("rst_wr_addr", wr_addr, 0);
    check_val("rst_wr_data", wr_data, 0);
    check_val("rst_mean_addr", mean_addr, 0);
    check_val("rst_found", mean_addr_found, 0);
    check_val("rst_level", level, 12'h800);

    // Ramp trigger.
    step(0, 0, 0, 0);
    measure4(12'h100, 12'hF00, 12'h100, 12'hF00);
    check_val("ramp_level", level, 12'h800);
    sample(12'h700);
    check_val("ramp_no_trig_yet", mean_addr, 0);
    sample(12'h900);
    check_val("ramp_mean_addr", mean_addr, 5);
    for (int i = 0; i < POST_SAMPLES; ) begin
      bit v;
      v = $urandom_range(0, 2) != 0;
      if (i == POST_SAMPLES - 1) check_val("ramp_found_early", mean_addr_found, 0);
      step(0, v, $urandom_range(0, 4095), 0);
      if (v) i++;
    end
    check_val("ramp_found", mean_addr_found, 1);

    // HOLD freeze, then frame_done together with adc_valid.
    for (int i = 0; i < 100; i++) begin
      step(0, 1, $urandom_range(0, 4095), 0);
      check_val("hold_wr_en", wr_en, 0);
    end
    step(0, 1, 12'hABC, 1);
    check_val("fd_valid_no_write", wr_en, 0);
    check_val("fd_found", mean_addr_found, 0);
    sample(12'h100);
    check_val("resume_addr", wr_addr, 6 + POST_SAMPLES);

    // First ARM sample never triggers; a falling edge never triggers.
    sample(12'hF00); sample(12'hF00); sample(12'h100);
    check_val("m2_level", level, 12'h800);
    sample(12'h900);
    check_val("first_arm_no_trig", mean_addr, 5);
    sample(12'h700);
    check_val("falling_no_trig", mean_addr, 5);
    sample(12'h900);
    check_val("rise_mean_addr", mean_addr, 6 + POST_SAMPLES + 6);
    finish_post_random();
    release_hold();
    // release_hold wrote nothing; that cycle only moved to MEASURE.

    // Flat input: only the timeout can trigger.
    base = 6 + POST_SAMPLES + 7 + POST_SAMPLES;
    measure4(12'h400, 12'h400, 12'h400, 12'h400);
    check_val("flat_level", level, 12'h400);
    for (int i = 0; i < ARM_TIMEOUT; ) begin
      bit v;
      v = $urandom_range(0, 3) != 0;
      step(0, v, 12'h400, 0);
      if (v) i++;
    end
    check_val("flat_no_trig", mean_addr, 6 + POST_SAMPLES + 6);
    sample(12'h400);
    check_val("auto_mean_addr", mean_addr, base + 4 + ARM_TIMEOUT);
    finish_post_random();
    release_hold();

    // Fully random traffic, including stray frame_done pulses.
    for (int i = 0; i < 1500; i++)
      step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 4095), $urandom_range(0, 9) == 0);

    // Reset in the middle of POST.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    measure4(12'h100, 12'hF00, 12'h100, 12'hF00);
    sample(12'h700);
    sample(12'h900);
    check_val("rp_mean_addr", mean_addr, 5);
    for (int i = 0; i < 10; i++) sample($urandom_range(0, 4095));
    step(1, 1, 12'h555, 1);
    check_val("rp_wr_en", wr_en, 0);
    check_val("rp_mean_addr0", mean_addr, 0);
    check_val("rp_found", mean_addr_found, 0);
    check_val("rp_level", level, 12'h800);

    // Pointer wrap: captures of chosen lengths bring the trigger to 0xFFFE.
    step(0, 0, 0, 0);
    guard = 0;
    while (guard < 3000) begin
      guard++;
      r_dist = 65534 - m_ptr;
      if (r_dist - 4 >= 1 && r_dist - 4 <= ARM_TIMEOUT) begin
        measure4(12'h100, 12'hF00, 12'h100, 12'hF00);
        for (int k = 0; k < r_dist - 4; k++) sample(12'h100);
        sample(12'h900);
        check_val("wrap_mean_addr", mean_addr, 16'hFFFE);
        sample($urandom_range(0, 4095));
        check_val("wrap_addr_ffff", wr_addr, 16'hFFFF);
        sample($urandom_range(0, 4095));
        check_val("wrap_addr_0000", wr_addr, 16'h0000);
        sample($urandom_range(0, 4095));
        check_val("wrap_addr_0001", wr_addr, 16'h0001);
        finish_post_random();
        release_hold();
        break;
      end
      if (r_dist > 100) a_len = 2;
      else begin
        a_len = r_dist - 58;
        if (a_len < 2) a_len = 2;
        if (a_len > ARM_TIMEOUT + 1) a_len = ARM_TIMEOUT + 1;
      end
      measure4(12'h100, 12'hF00, 12'h100, 12'hF00);
      for (int k = 0; k < a_len - 1; k++) sample(12'h100);
      sample(12'h900);
      for (int k = 0; k < POST_SAMPLES; k++) sample($urandom_range(0, 4095));
      step(0, 0, 0, 1);
    end
    check_val("wrap_reached", guard < 3000, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
